multicycle_ctrl: RTL

- Next-generation multicycle ARM-subset controller: main FSM, ALU decoder and PC logic in one block.
- Sits between the instruction register fields (Op, Funct, Rd) and the multicycle datapath.
- Adds a wider ALU control (EOR, CMP, MUL), an iterative multiply state with a cycle counter, and a MemReady wait handshake on every memory access.

---
 rtl/multicycle_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle ARM-subset main FSM, ALU decoder and PC-write logic with MemReady waits and iterative MUL
module multicycle_ctrl #(
  parameter int ALU_W      = 3,
  parameter int MUL_EN     = 1,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  input  logic             IsMul,
  input  logic             MemReady,
  output logic [1:0]       FlagW,
  output logic             PCS,
  output logic             NextPC,
  output logic             RegW,
  output logic             MemW,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       RegSrc,
  output logic [ALU_W-1:0] ALUControl,
  output logic             MulBusy,
  output logic [3:0]       StateDbg
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, MULEXEC
  } state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic [3:0] cmd;
  logic [2:0] ctl;
  logic alu_op, branch;
  assign cmd = Funct[4:1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= next;
      cnt   <= (state == DECODE && next == MULEXEC) ? 4'(MUL_CYCLES - 1) :
               (state == MULEXEC && cnt != 4'd0) ? cnt - 4'd1 : cnt;
    end
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:    next = MemReady ? DECODE : FETCH;
      DECODE:   next = (Op == 2'b01) ? MEMADR :
                       (Op == 2'b00 && IsMul && MUL_EN != 0) ? MULEXEC :
                       (Op == 2'b00 && Funct[5]) ? EXECUTEI :
                       (Op == 2'b00) ? EXECUTER :
                       (Op == 2'b10) ? BRANCH : FETCH;
      MEMADR:   next = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  next = MemReady ? MEMWB : MEMREAD;
      MEMWRITE: next = MemReady ? FETCH : MEMWRITE;
      EXECUTER: next = ALUWB;
      EXECUTEI: next = ALUWB;
      MULEXEC:  next = (cnt == 4'd0) ? ALUWB : MULEXEC;
      default:  next = FETCH;
    endcase
  end
  // FETCH strobes are gated by reset so nothing fires while reset is held
  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 1'b0;
    branch    = 1'b0;
    MulBusy   = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady & reset;
        NextPC    = MemReady & reset;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: alu_op = 1'b1;
      EXECUTEI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      MULEXEC: begin
        alu_op  = 1'b1;
        MulBusy = 1'b1;
      end
      ALUWB:    RegW = (cmd != 4'b1010);
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end
  always_comb begin
    ctl = (state == MULEXEC) ? 3'b101 :
          (cmd == 4'b0010 || cmd == 4'b1010) ? 3'b001 :
          (cmd == 4'b0000) ? 3'b010 :
          (cmd == 4'b1100) ? 3'b011 :
          (cmd == 4'b0001) ? 3'b100 : 3'b000;
    ALUControl = alu_op ? ALU_W'(ctl) : '0;
    FlagW = !alu_op ? 2'b00 :
            (state == MULEXEC) ? {Funct[0], 1'b0} :
            (cmd == 4'b1010) ? 2'b11 :
            {Funct[0], Funct[0] & (cmd == 4'b0100 || cmd == 4'b0010)};
  end
  assign PCS      = (Rd == 4'hF && RegW) || branch;
  assign ImmSrc   = Op;
  assign RegSrc   = {Op == 2'b01, Op == 2'b10};
  assign StateDbg = state;
endmodule
